// File: rtl/pio_csr_slave.sv
// PIO control/status register slave with a configurable read-latency pipeline.
// Optional feature: define PIO_CSR_ERR_CNT_EN to add the ERR_CNT register at 0x1C.
module pio_csr_slave #(
   parameter int          RD_LAT = 1,
   parameter logic [31:0] ID_VAL = 32'h5A5A_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_vld,
   input  logic [15:0] addr,
   input  logic [31:0] data_w,
   input  logic        rw,
   output logic [31:0] data_r,
   output logic        rd_vld,
   input  logic [31:0] status_i,
   input  logic [7:0]  event_i,
   output logic [31:0] ctrl_o,
   output logic        irq
);

   localparam logic [2:0] IDX_ID      = 3'd0;
   localparam logic [2:0] IDX_SCRATCH = 3'd1;
   localparam logic [2:0] IDX_CTRL    = 3'd2;
   localparam logic [2:0] IDX_STATUS  = 3'd3;
   localparam logic [2:0] IDX_IRQ_ST  = 3'd4;
   localparam logic [2:0] IDX_IRQ_MSK = 3'd5;
   localparam logic [2:0] IDX_CMD_CNT = 3'd6;
   localparam logic [2:0] IDX_ERR_CNT = 3'd7;
   localparam logic [31:0] BAD_DATA   = 32'hDEAD_BEEF;

   logic [31:0] scratch_reg;
   logic [31:0] ctrl_reg;
   logic [7:0]  irq_stat_reg;
   logic [7:0]  irq_mask_reg;
   logic [31:0] cmd_cnt_reg;
   logic        irq_reg;

   logic        in_window;
   logic [2:0]  widx;
   logic        readable;
   logic        writable;
   logic        wr_acc;
   logic        rd_acc;
   logic        bad_acc;
   logic [31:0] rd_mux;
   logic [7:0]  irq_stat_next;

   assign in_window = (addr[1:0] == 2'b00) && (addr[15:5] == 11'd0);
   assign widx      = addr[4:2];

`ifdef PIO_CSR_ERR_CNT_EN
   logic [15:0] err_cnt_reg;
   assign readable = in_window;
`else
   assign readable = in_window && (widx != IDX_ERR_CNT);
`endif

   assign writable = in_window && ((widx == IDX_SCRATCH) || (widx == IDX_CTRL) ||
                                   (widx == IDX_IRQ_ST)  || (widx == IDX_IRQ_MSK));
   assign wr_acc   = cmd_vld && rw && writable;
   assign rd_acc   = cmd_vld && !rw;
   assign bad_acc  = cmd_vld && (rw ? !writable : !readable);

   // Read data reflects register contents before this edge's own write or count.
   always_comb begin
      rd_mux = BAD_DATA;
      if (readable) begin
         case (widx)
            IDX_ID:      rd_mux = ID_VAL;
            IDX_SCRATCH: rd_mux = scratch_reg;
            IDX_CTRL:    rd_mux = ctrl_reg;
            IDX_STATUS:  rd_mux = status_i;
            IDX_IRQ_ST:  rd_mux = {24'd0, irq_stat_reg};
            IDX_IRQ_MSK: rd_mux = {24'd0, irq_mask_reg};
            IDX_CMD_CNT: rd_mux = cmd_cnt_reg;
`ifdef PIO_CSR_ERR_CNT_EN
            IDX_ERR_CNT: rd_mux = {16'd0, err_cnt_reg};
`endif
            default:     rd_mux = BAD_DATA;
         endcase
      end
   end

   // New events win over a simultaneous write-one-to-clear.
   always_comb begin
      irq_stat_next = irq_stat_reg;
      if (wr_acc && (widx == IDX_IRQ_ST)) begin
         irq_stat_next = irq_stat_reg & ~data_w[7:0];
      end
      irq_stat_next = irq_stat_next | event_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch_reg  <= '0;
         ctrl_reg     <= '0;
         irq_stat_reg <= '0;
         irq_mask_reg <= '0;
         cmd_cnt_reg  <= '0;
         irq_reg      <= 1'b0;
      end else begin
         irq_stat_reg <= irq_stat_next;
         irq_reg      <= |(irq_stat_reg & irq_mask_reg);
         if (cmd_vld) begin
            cmd_cnt_reg <= cmd_cnt_reg + 32'd1;
         end
         if (wr_acc) begin
            case (widx)
               IDX_SCRATCH: scratch_reg  <= data_w;
               IDX_CTRL:    ctrl_reg     <= data_w;
               IDX_IRQ_MSK: irq_mask_reg <= data_w[7:0];
               default:     ;
            endcase
         end
      end
   end

`ifdef PIO_CSR_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_reg <= '0;
      end else if (bad_acc && (err_cnt_reg != 16'hFFFF)) begin
         err_cnt_reg <= err_cnt_reg + 16'd1;
      end
   end
`else
   logic unused_bad_acc;
   assign unused_bad_acc = bad_acc;
`endif

   // Read pipeline; data is held at zero in idle stages so data_r needs no output gating.
   logic        vld_pipe [RD_LAT];
   logic [31:0] dat_pipe [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[0] <= 1'b0;
         dat_pipe[0] <= '0;
      end else begin
         vld_pipe[0] <= rd_acc;
         dat_pipe[0] <= rd_acc ? rd_mux : 32'd0;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < RD_LAT; gi++) begin : g_rd_stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_pipe[gi] <= 1'b0;
               dat_pipe[gi] <= '0;
            end else begin
               vld_pipe[gi] <= vld_pipe[gi-1];
               dat_pipe[gi] <= dat_pipe[gi-1];
            end
         end
      end
   endgenerate

   assign rd_vld = vld_pipe[RD_LAT-1];
   assign data_r = dat_pipe[RD_LAT-1];
   assign ctrl_o = ctrl_reg;
   assign irq    = irq_reg;

endmodule
